// File: rtl/md_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional build macro MD_EARLY_OUT_EN: multiplies finish once the remaining multiplier is zero.
module md_sequencer #(
    parameter int WORD_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(WORD_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [2:0]            md_op_i,
    input  logic [WORD_WIDTH-1:0] operand_a_i,
    input  logic [WORD_WIDTH-1:0] operand_b_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  valid_o,
    output logic [WORD_WIDTH-1:0] result_o
);
    localparam int W = WORD_WIDTH;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    logic [1:0]           state_reg;
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic [2:0]           op_reg;
    logic [2*W-1:0]       acc_reg;     // product, or {remainder, quotient/dividend}
    logic [2*W-1:0]       mcand_reg;   // shifted multiplicand; divisor in the low half
    logic [W-1:0]         mplier_reg;
    logic                 neg_q_reg;
    logic                 neg_r_reg;
    logic [W-1:0]         result_reg;

    logic           a_signed, b_signed, sa, sb;
    logic [W-1:0]   mag_a, mag_b;
    logic           div_zero, div_ovf, accept;
    logic [2*W-1:0] mul_sum, mcand_shift;
    logic [W-1:0]   mplier_shift;
    logic           mul_last;
    logic [W:0]     rem_shift;
    logic           rem_ge;
    logic [W-1:0]   rem_sub;
    logic [2*W-1:0] div_next;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix, rem_fix, done_result;

    assign accept   = (state_reg == ST_IDLE) && valid_i && !flush_i;
    assign a_signed = (md_op_i == 3'b001) || (md_op_i == 3'b010) || (md_op_i == 3'b100) || (md_op_i == 3'b110);
    assign b_signed = (md_op_i == 3'b001) || (md_op_i == 3'b100) || (md_op_i == 3'b110);
    assign sa       = a_signed && operand_a_i[W-1];
    assign sb       = b_signed && operand_b_i[W-1];
    assign mag_a    = sa ? ('0 - operand_a_i) : operand_a_i;
    assign mag_b    = sb ? ('0 - operand_b_i) : operand_b_i;
    assign div_zero = md_op_i[2] && (operand_b_i == '0);
    assign div_ovf  = md_op_i[2] && !md_op_i[0] && (operand_a_i == MIN_NEG) && (&operand_b_i);

    assign mul_sum      = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign mcand_shift  = {mcand_reg[2*W-2:0], 1'b0};
    assign mplier_shift = {1'b0, mplier_reg[W-1:1]};
`ifdef MD_EARLY_OUT_EN
    assign mul_last = (cnt_reg == '0) || (mplier_shift == '0);
`else
    assign mul_last = (cnt_reg == '0);
`endif

    // Partial remainder needs W+1 bits after the shift before the trial subtract.
    assign rem_shift = {acc_reg[2*W-1:W], acc_reg[W-1]};
    assign rem_ge    = rem_shift >= {1'b0, mcand_reg[W-1:0]};
    assign rem_sub   = W'(rem_shift - {1'b0, mcand_reg[W-1:0]});
    assign div_next  = rem_ge ? {rem_sub, acc_reg[W-2:0], 1'b1}
                              : {rem_shift[W-1:0], acc_reg[W-2:0], 1'b0};

    assign prod_fix = neg_q_reg ? ('0 - acc_reg) : acc_reg;
    assign quo_fix  = neg_q_reg ? ('0 - acc_reg[W-1:0]) : acc_reg[W-1:0];
    assign rem_fix  = neg_r_reg ? ('0 - acc_reg[2*W-1:W]) : acc_reg[2*W-1:W];

    always_comb begin
        done_result = prod_fix[W-1:0];
        case (op_reg)
            3'b000:                 done_result = prod_fix[W-1:0];
            3'b001, 3'b010, 3'b011: done_result = prod_fix[2*W-1:W];
            3'b100, 3'b101:         done_result = quo_fix;
            default:                done_result = rem_fix;
        endcase
    end

    assign ready_o  = (state_reg == ST_IDLE);
    assign stall_o  = (state_reg == ST_IDLE) ? (valid_i && !flush_i) : 1'b1;
    assign valid_o  = (state_reg == ST_DONE) && !flush_i;
    assign result_o = (state_reg == ST_DONE) ? done_result : result_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            op_reg     <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            result_reg <= '0;
        end else if (flush_i) begin
            state_reg <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: if (accept) begin
                    op_reg  <= md_op_i;
                    cnt_reg <= CNT_WIDTH'(W - 1);
                    // Fast paths load the final {remainder, quotient} with no sign fix-up.
                    if (div_zero) begin
                        acc_reg   <= {operand_a_i, {W{1'b1}}};
                        neg_q_reg <= 1'b0;
                        neg_r_reg <= 1'b0;
                        state_reg <= ST_DONE;
                    end else if (div_ovf) begin
                        acc_reg   <= {{W{1'b0}}, MIN_NEG};
                        neg_q_reg <= 1'b0;
                        neg_r_reg <= 1'b0;
                        state_reg <= ST_DONE;
                    end else if (md_op_i[2]) begin
                        acc_reg   <= {{W{1'b0}}, mag_a};
                        mcand_reg <= {{W{1'b0}}, mag_b};
                        neg_q_reg <= sa ^ sb;
                        neg_r_reg <= sa;
                        state_reg <= ST_DIV;
                    end else begin
                        acc_reg    <= '0;
                        mcand_reg  <= {{W{1'b0}}, mag_a};
                        mplier_reg <= mag_b;
                        neg_q_reg  <= sa ^ sb;
                        neg_r_reg  <= sa;
                        state_reg  <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    acc_reg    <= mul_sum;
                    mcand_reg  <= mcand_shift;
                    mplier_reg <= mplier_shift;
                    cnt_reg    <= cnt_reg - CNT_WIDTH'(1);
                    if (mul_last) state_reg <= ST_DONE;
                end
                ST_DIV: begin
                    acc_reg <= div_next;
                    cnt_reg <= cnt_reg - CNT_WIDTH'(1);
                    if (cnt_reg == '0) state_reg <= ST_DONE;
                end
                default: begin
                    result_reg <= done_result;
                    state_reg  <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
